kfpga_config_loader: RTL and testbench



---
 rtl/kfpga_config_loader_pkg.sv | 23 ++
 rtl/kfpga_config_loader.sv | 133 +++++++++++++
 tb/tb_kfpga_config_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kfpga_config_loader_pkg.sv
// Shared types for the kFPGA configuration loader: header magic, FSM states
// and the error codes reported to software.
package kfpga_config_pkg;

  localparam logic [15:0] CFG_MAGIC = 16'hCF6A;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOAD,
    CHECKSUM,
    DONE,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MAGIC,
    ERR_LENGTH,
    ERR_CHECKSUM
  } err_t;

endpackage

// File: rtl/kfpga_config_loader.sv
// Streams the kFPGA bitstream into the wide config register, checks header and
// checksum, and releases the core from reset once the load is verified.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// HEADER   | expecting {magic, payload length}
// LOAD     | shifting payload words into config_out, summing them
// CHECKSUM | expecting the 32-bit sum of all payload words
// DONE     | verified; core released from reset
// ERROR    | load rejected; error_code holds the reason
module kfpga_config_loader
  import kfpga_config_pkg::*;
#(
  parameter int CONFIG_WIDTH = 34688,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    core_nreset,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              error_code
);

  localparam int NUM_WORDS = CONFIG_WIDTH / WORD_WIDTH;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  localparam logic [15:0]      LEN_FIELD = 16'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_WORDS - 1);

  if (CONFIG_WIDTH % WORD_WIDTH != 0) begin : g_width_check
    $error("kfpga_config_loader: CONFIG_WIDTH must be a multiple of WORD_WIDTH");
  end
  if (WORD_WIDTH < 32) begin : g_word_check
    $error("kfpga_config_loader: header needs WORD_WIDTH of at least 32");
  end

  state_t                  state;
  err_t                    code_q;
  logic [CNT_W-1:0]        count;
  logic [WORD_WIDTH-1:0]   acc;
  logic [CONFIG_WIDTH-1:0] shifted;
  logic                    xfer;

  // Newest word enters at the top so the first payload word ends up at bit 0.
  if (NUM_WORDS > 1) begin : g_shift
    assign shifted = {s_data, config_out[CONFIG_WIDTH-1:WORD_WIDTH]};
  end else begin : g_single
    assign shifted = s_data;
  end

  assign busy    = (state == HEADER) || (state == LOAD) || (state == CHECKSUM);
  assign s_ready = busy && !start;
  assign xfer    = s_valid && s_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      code_q      <= ERR_NONE;
      count       <= '0;
      acc         <= '0;
      config_out  <= '0;
      core_nreset <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      error_code  <= ERR_NONE;
    end else if (start) begin
      // config_out is left alone: the core stays in reset until it is rewritten.
      state       <= HEADER;
      code_q      <= ERR_NONE;
      count       <= '0;
      acc         <= '0;
      core_nreset <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      error_code  <= ERR_NONE;
    end else begin
      case (state)
        IDLE: ;
        HEADER: begin
          if (xfer) begin
            if (s_data[WORD_WIDTH-1 -: 16] != CFG_MAGIC) begin
              state  <= ERROR;
              code_q <= ERR_MAGIC;
            end else if (s_data[15:0] != LEN_FIELD) begin
              state  <= ERROR;
              code_q <= ERR_LENGTH;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            config_out <= shifted;
            acc        <= acc + s_data;
            count      <= count + CNT_W'(1);
            if (count == LAST_IDX) state <= CHECKSUM;
          end
        end
        CHECKSUM: begin
          if (xfer) begin
            if (s_data == acc) begin
              state <= DONE;
            end else begin
              state  <= ERROR;
              code_q <= ERR_CHECKSUM;
            end
          end
        end
        // Flags follow the state by one edge, so the core leaves reset one
        // cycle after the checksum word is accepted.
        DONE: begin
          done        <= 1'b1;
          core_nreset <= 1'b1;
        end
        ERROR: begin
          error       <= 1'b1;
          core_nreset <= 1'b0;
          error_code  <= code_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kfpga_config_loader.sv
// Scoreboard bench for kfpga_config_loader: a 128-bit instance for directed
// streams and a default-width instance for the full-size load.
module tb_kfpga_config_loader;

  localparam int AW = 128;
  localparam int BW = 34688;
  localparam int BN = BW / 32;
  localparam logic [AW-1:0] CFG4 = 128'h00000004_00000003_00000002_00000001;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          a_start, a_valid, a_s_ready, a_core_nreset, a_busy, a_done, a_error;
  logic [31:0]   a_data;
  logic [AW-1:0] a_config_out;
  logic [1:0]    a_error_code;

  logic          b_start, b_valid, b_s_ready, b_core_nreset, b_busy, b_done, b_error;
  logic [31:0]   b_data;
  logic [BW-1:0] b_config_out;
  logic [1:0]    b_error_code;

  kfpga_config_loader #(.CONFIG_WIDTH(AW), .WORD_WIDTH(32)) u_a (
    .clock(clock), .reset(reset), .start(a_start), .s_data(a_data), .s_valid(a_valid),
    .s_ready(a_s_ready), .config_out(a_config_out), .core_nreset(a_core_nreset),
    .busy(a_busy), .done(a_done), .error(a_error), .error_code(a_error_code)
  );

  kfpga_config_loader u_b (
    .clock(clock), .reset(reset), .start(b_start), .s_data(b_data), .s_valid(b_valid),
    .s_ready(b_s_ready), .config_out(b_config_out), .core_nreset(b_core_nreset),
    .busy(b_busy), .done(b_done), .error(b_error), .error_code(b_error_code)
  );

  typedef struct {
    logic          done;
    logic          err;
    logic [1:0]    code;
    logic          nres;
    logic          chk_cfg;
    logic [AW-1:0] cfg;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;
  int a_last_acc = 0;
  int b_last_acc = 0;
  int b_acc_cnt = 0;
  int inv_prints = 0;
  logic a_prev = 1'b0;
  logic b_prev = 1'b0;

  logic [31:0]   b_words [BN];
  logic [BW-1:0] b_exp_cfg;
  logic [31:0]   b_sum;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic inv_fail(input string name);
    miscompares++;
    if (inv_prints < 10) $display("FAIL %s at edge %0d", name, edge_cnt);
    inv_prints++;
  endtask

  // Handshake bookkeeping: edge index of the last transfer, and transfer count.
  always @(posedge clock) begin
    edge_cnt <= edge_cnt + 1;
    if (!reset && a_valid && a_s_ready) a_last_acc <= edge_cnt + 1;
    if (!reset && b_valid && b_s_ready) begin
      b_last_acc <= edge_cnt + 1;
      b_acc_cnt  <= b_acc_cnt + 1;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (a_s_ready && !a_busy) inv_fail("a_sready_outside_busy");
      if (a_core_nreset && a_busy) inv_fail("a_nreset_while_busy");
      if (int'(a_busy) + int'(a_done) + int'(a_error) > 1) inv_fail("a_flags_exclusive");
      if (b_s_ready && !b_busy) inv_fail("b_sready_outside_busy");
      if (b_core_nreset && b_busy) inv_fail("b_nreset_while_busy");
      if (int'(b_busy) + int'(b_done) + int'(b_error) > 1) inv_fail("b_flags_exclusive");
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset && (a_done || a_error) && !a_prev) begin
      if (qa.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL a_unexpected_end: done=%b error=%b code=%0d with nothing expected",
                 a_done, a_error, a_error_code);
      end else begin
        e = qa.pop_front();
        check("a_done", 128'(a_done), 128'(e.done));
        check("a_error", 128'(a_error), 128'(e.err));
        check("a_error_code", 128'(a_error_code), 128'(e.code));
        check("a_core_nreset", 128'(a_core_nreset), 128'(e.nres));
        check("a_latency_edge", 128'(edge_cnt), 128'(a_last_acc + 1));
        if (e.chk_cfg) check("a_config_out", a_config_out, e.cfg);
      end
    end
    a_prev <= a_done || a_error;
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset && (b_done || b_error) && !b_prev) begin
      if (qb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL b_unexpected_end: done=%b error=%b code=%0d with nothing expected",
                 b_done, b_error, b_error_code);
      end else begin
        e = qb.pop_front();
        check("b_done", 128'(b_done), 128'(e.done));
        check("b_error", 128'(b_error), 128'(e.err));
        check("b_error_code", 128'(b_error_code), 128'(e.code));
        check("b_core_nreset", 128'(b_core_nreset), 128'(e.nres));
        check("b_latency_edge", 128'(edge_cnt), 128'(b_last_acc + 1));
        check("b_accepted_words", 128'(b_acc_cnt), 128'(BN + 2));
        check("b_config_low_word", 128'(b_config_out[31:0]), 128'(b_words[0]));
        check("b_config_full_equal", 128'(b_config_out == b_exp_cfg), 128'(1));
      end
    end
    b_prev <= b_done || b_error;
  end

  task automatic push_a(input logic d, input logic er, input logic [1:0] c, input logic n,
                        input logic chk, input logic [AW-1:0] cfg);
    exp_t e;
    e.done = d; e.err = er; e.code = c; e.nres = n; e.chk_cfg = chk; e.cfg = cfg;
    qa.push_back(e);
  endtask

  task automatic a_send(input logic [31:0] w, input int duty);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 300) begin
      @(negedge clock);
      a_start = 1'b0;
      a_valid = ($urandom_range(0, 99) < duty);
      a_data  = w;
      #1;
      acc = a_valid && a_s_ready;
      tries++;
      @(posedge clock);
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL a_send_timeout: word %h not accepted after %0d cycles", w, tries);
    end
    #1 a_valid = 1'b0;
  endtask

  task automatic a_start_pulse(input logic with_valid, input logic [31:0] d);
    @(negedge clock);
    a_start = 1'b1;
    a_valid = with_valid;
    a_data  = d;
    #1;
    check("a_sready_during_start", 128'(a_s_ready), 128'(0));
    @(posedge clock);
    #1;
    a_start = 1'b0;
    a_valid = 1'b0;
  endtask

  task automatic a_stream(input logic [31:0] csum, input int duty);
    a_send(32'hCF6A0004, duty);
    for (int i = 1; i <= 4; i++) a_send(32'(i), duty);
    a_send(csum, duty);
  endtask

  task automatic a_drain();
    int n;
    n = 0;
    while (qa.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (qa.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL a_drain_timeout: %0d expected results never seen", qa.size());
      qa.delete();
    end
  endtask

  task automatic a_check_reset(input string tag);
    check({tag, "_config_out"}, a_config_out, 128'(0));
    check({tag, "_core_nreset"}, 128'(a_core_nreset), 128'(0));
    check({tag, "_s_ready"}, 128'(a_s_ready), 128'(0));
    check({tag, "_busy"}, 128'(a_busy), 128'(0));
    check({tag, "_done"}, 128'(a_done), 128'(0));
    check({tag, "_error"}, 128'(a_error), 128'(0));
    check({tag, "_error_code"}, 128'(a_error_code), 128'(0));
  endtask

  task automatic b_send(input logic [31:0] w);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 50) begin
      @(negedge clock);
      b_valid = 1'b1;
      b_data  = w;
      #1;
      acc = b_s_ready;
      tries++;
      @(posedge clock);
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL b_send_timeout: word %h not accepted after %0d cycles", w, tries);
    end
    #1 b_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t eb;
    a_start = 0; a_valid = 0; a_data = '0;
    b_start = 0; b_valid = 0; b_data = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    a_check_reset("reset");
    reset = 1'b0;

    // Clean load, valid held high; words presented in DONE must be refused.
    push_a(1, 0, 2'd0, 1, 1, CFG4);
    a_start_pulse(0, 32'h0);
    a_stream(32'h0000000A, 100);
    a_drain();
    @(negedge clock);
    a_valid = 1'b1;
    a_data  = 32'h00000005;
    #1;
    check("a_sready_in_done", 128'(a_s_ready), 128'(0));
    check("a_done_holds", 128'(a_done), 128'(1));
    a_valid = 1'b0;

    // Same stream with a sparse valid.
    push_a(1, 0, 2'd0, 1, 1, CFG4);
    a_start_pulse(0, 32'h0);
    a_stream(32'h0000000A, 30);
    a_drain();

    push_a(0, 1, 2'd1, 0, 0, '0);
    a_start_pulse(0, 32'h0);
    a_send(32'hCF6B0004, 100);
    a_drain();

    push_a(0, 1, 2'd2, 0, 0, '0);
    a_start_pulse(0, 32'h0);
    a_send(32'hCF6A0005, 100);
    a_drain();

    push_a(0, 1, 2'd3, 0, 1, CFG4);
    a_start_pulse(0, 32'h0);
    a_stream(32'h0000000B, 100);
    a_drain();

    // Restart after two payload words; the word offered with start is dropped.
    push_a(1, 0, 2'd0, 1, 1, CFG4);
    a_start_pulse(0, 32'h0);
    a_send(32'hCF6A0004, 100);
    a_send(32'h00000001, 100);
    a_send(32'h00000002, 100);
    a_start_pulse(1, 32'h00000007);
    a_stream(32'h0000000A, 100);
    a_drain();

    // Reset in the middle of LOAD, then a full load.
    a_start_pulse(0, 32'h0);
    a_send(32'hCF6A0004, 100);
    a_send(32'h00000009, 100);
    a_send(32'h00000008, 100);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    a_check_reset("midload_reset");
    reset = 1'b0;
    push_a(1, 0, 2'd0, 1, 1, CFG4);
    a_start_pulse(0, 32'h0);
    a_stream(32'h0000000A, 100);
    a_drain();

    // Full-size load on the default-width instance.
    b_sum = '0;
    for (int i = 0; i < BN; i++) begin
      b_words[i] = $urandom;
      b_exp_cfg[32*i +: 32] = b_words[i];
      b_sum = b_sum + b_words[i];
    end
    eb.done = 1; eb.err = 0; eb.code = 2'd0; eb.nres = 1; eb.chk_cfg = 0; eb.cfg = '0;
    qb.push_back(eb);
    @(negedge clock);
    b_start = 1'b1;
    #1;
    check("b_sready_during_start", 128'(b_s_ready), 128'(0));
    @(posedge clock);
    #1 b_start = 1'b0;
    b_send(32'hCF6A043C);
    for (int i = 0; i < BN; i++) b_send(b_words[i]);
    b_send(b_sum);
    begin
      int n;
      n = 0;
      while (qb.size() != 0 && n < 100) begin
        @(negedge clock);
        n++;
      end
      if (qb.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL b_drain_timeout: %0d expected results never seen", qb.size());
      end
    end

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
